// File: rtl/visualiser_mode_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : visualiser_mode_ctrl
//  Description : Frame-synchronous selector between the normal volume
//                visualiser and the high-volume image. The 5-bit audio level
//                goes through attack qualification, hysteresis and a hold
//                timer so the display does not flicker near threshold.
//                Source changes are committed only on frame_start, so a
//                frame is never torn. Dropping enable is the one exception:
//                it switches back to the normal image at once.
//  Ports       : basys_clock  - system clock (rising edge)
//                rst_n        - asynchronous active-low reset
//                enable       - loud-mode enable; low forces normal display
//                volume[4:0]  - current audio level, unsigned
//                sample_tick  - one-cycle pulse per audio sample
//                frame_start  - one-cycle pulse at pixel_index wrap
//                src_normal   - normal visualiser pixel
//                src_loud     - loud image pixel
//                oled_data    - selected pixel (combinational mux)
//                loud_active  - registered select, 1 = loud image shown
//                state_o[2:0] - FSM state encoding
//                switch_pulse - one-cycle pulse when loud_active changes
//  Revision    : 1.0 - initial release
// ============================================================================
module visualiser_mode_ctrl #(
    parameter int unsigned HI_THRESH      = 10,
    parameter int unsigned LO_THRESH      = 7,
    parameter int unsigned ATTACK_SAMPLES = 4,
    parameter int unsigned HOLD_SAMPLES   = 2000
) (
    input  logic        basys_clock,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [4:0]  volume,
    input  logic        sample_tick,
    input  logic        frame_start,
    input  logic [15:0] src_normal,
    input  logic [15:0] src_loud,
    output logic [15:0] oled_data,
    output logic        loud_active,
    output logic [2:0]  state_o,
    output logic        switch_pulse
);

    typedef enum logic [2:0] {
        S_NORMAL      = 3'd0,
        S_ATTACK      = 3'd1,
        S_LOUD_PEND   = 3'd2,
        S_LOUD        = 3'd3,
        S_HOLD        = 3'd4,
        S_NORMAL_PEND = 3'd5
    } state_t;

    localparam logic [4:0]  c_HI     = 5'(HI_THRESH);
    localparam logic [4:0]  c_LO     = 5'(LO_THRESH);
    localparam logic [15:0] c_ATTACK = 16'(ATTACK_SAMPLES);
    localparam logic [15:0] c_HOLD   = 16'(HOLD_SAMPLES);

    state_t      r_state;
    logic [15:0] r_cnt;
    logic        r_sel;
    logic        r_pulse;

    state_t      w_state_nx;
    logic [15:0] w_cnt_nx;
    logic        w_sel_nx;
    logic        w_pulse_nx;

    logic        w_loud;
    logic        w_quiet;
    logic [15:0] w_cnt_inc;

    assign w_loud    = (volume >= c_HI);
    assign w_quiet   = (volume <  c_LO);
    assign w_cnt_inc = r_cnt + 16'd1;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge basys_clock or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_NORMAL;
            r_cnt   <= 16'd0;
            r_sel   <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_sel   <= w_sel_nx;
            r_pulse <= w_pulse_nx;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_sel_nx   = r_sel;
        w_pulse_nx = 1'b0;

        if (!enable) begin
            // User action: fall back immediately, no frame alignment.
            w_state_nx = S_NORMAL;
            w_cnt_nx   = 16'd0;
            if (r_sel) begin
                w_sel_nx   = 1'b0;
                w_pulse_nx = 1'b1;
            end
        end else begin
            case (r_state)
                S_NORMAL: begin
                    if (sample_tick && w_loud) begin
                        w_cnt_nx   = 16'd1;
                        w_state_nx = (c_ATTACK == 16'd1) ? S_LOUD_PEND : S_ATTACK;
                    end
                end

                S_ATTACK: begin
                    if (sample_tick) begin
                        if (w_loud) begin
                            w_cnt_nx = w_cnt_inc;
                            if (w_cnt_inc == c_ATTACK) begin
                                w_state_nx = S_LOUD_PEND;
                            end
                        end else begin
                            w_state_nx = S_NORMAL;
                            w_cnt_nx   = 16'd0;
                        end
                    end
                end

                // Waiting for a frame boundary; ticks are dropped here.
                S_LOUD_PEND: begin
                    if (frame_start) begin
                        w_state_nx = S_LOUD;
                        w_cnt_nx   = 16'd0;
                        w_sel_nx   = 1'b1;
                        w_pulse_nx = 1'b1;
                    end
                end

                // Volume in [LO, HI) keeps LOUD: that gap is the hysteresis band.
                S_LOUD: begin
                    if (sample_tick && w_quiet) begin
                        w_cnt_nx   = 16'd1;
                        w_state_nx = (c_HOLD == 16'd1) ? S_NORMAL_PEND : S_HOLD;
                    end
                end

                S_HOLD: begin
                    if (sample_tick) begin
                        if (w_quiet) begin
                            w_cnt_nx = w_cnt_inc;
                            if (w_cnt_inc == c_HOLD) begin
                                w_state_nx = S_NORMAL_PEND;
                            end
                        end else begin
                            w_state_nx = S_LOUD;
                            w_cnt_nx   = 16'd0;
                        end
                    end
                end

                // frame_start has priority; a loud tick re-arms LOUD without
                // ever having left the loud image, so no pulse.
                S_NORMAL_PEND: begin
                    if (frame_start) begin
                        w_state_nx = S_NORMAL;
                        w_cnt_nx   = 16'd0;
                        w_sel_nx   = 1'b0;
                        w_pulse_nx = 1'b1;
                    end else if (sample_tick && w_loud) begin
                        w_state_nx = S_LOUD;
                        w_cnt_nx   = 16'd0;
                    end
                end

                default: begin
                    w_state_nx = S_NORMAL;
                    w_cnt_nx   = 16'd0;
                    w_sel_nx   = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign oled_data    = r_sel ? src_loud : src_normal;
    assign loud_active  = r_sel;
    assign state_o      = r_state;
    assign switch_pulse = r_pulse;

endmodule
`default_nettype wire

// File: tb/tb_visualiser_mode_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_visualiser_mode_ctrl
//  Description : Directed self-checking bench for visualiser_mode_ctrl,
//                built with HOLD_SAMPLES=5 so the hold timer is short.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_visualiser_mode_ctrl;

    localparam logic [15:0] c_SRC_N = 16'h1234;
    localparam logic [15:0] c_SRC_L = 16'hABCD;

    logic        basys_clock;
    logic        rst_n;
    logic        enable;
    logic [4:0]  volume;
    logic        sample_tick;
    logic        frame_start;
    logic [15:0] src_normal;
    logic [15:0] src_loud;
    logic [15:0] oled_data;
    logic        loud_active;
    logic [2:0]  state_o;
    logic        switch_pulse;

    int n_checks = 0;
    int n_err    = 0;
    int n_pulses = 0;

    visualiser_mode_ctrl #(
        .HI_THRESH      (10),
        .LO_THRESH      (7),
        .ATTACK_SAMPLES (4),
        .HOLD_SAMPLES   (5)
    ) u_dut (
        .basys_clock  (basys_clock),
        .rst_n        (rst_n),
        .enable       (enable),
        .volume       (volume),
        .sample_tick  (sample_tick),
        .frame_start  (frame_start),
        .src_normal   (src_normal),
        .src_loud     (src_loud),
        .oled_data    (oled_data),
        .loud_active  (loud_active),
        .state_o      (state_o),
        .switch_pulse (switch_pulse)
    );

    initial basys_clock = 1'b0;
    always #5 basys_clock = ~basys_clock;

    // Each pulse is high across exactly one rising edge, so this counts pulses.
    always @(posedge basys_clock) begin
        if (switch_pulse === 1'b1) n_pulses++;
    end

    // One clock with the given strobes, outputs observed 1 time unit later.
    task automatic cyc(input logic t, input logic f);
        sample_tick = t;
        frame_start = f;
        @(posedge basys_clock);
        #1;
        sample_tick = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic [2:0] st,
                             input logic la, input logic pl);
        logic [15:0] exp_pix;
        exp_pix = la ? c_SRC_L : c_SRC_N;
        n_checks++;
        assert (state_o === st) else begin
            n_err++;
            $error("FAIL %s state: observed %0d expected %0d", tag, state_o, st);
        end
        n_checks++;
        assert (loud_active === la) else begin
            n_err++;
            $error("FAIL %s loud_active: observed %b expected %b", tag, loud_active, la);
        end
        n_checks++;
        assert (switch_pulse === pl) else begin
            n_err++;
            $error("FAIL %s switch_pulse: observed %b expected %b", tag, switch_pulse, pl);
        end
        n_checks++;
        assert (oled_data === exp_pix) else begin
            n_err++;
            $error("FAIL %s oled_data: observed %h expected %h", tag, oled_data, exp_pix);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        enable      = 1'b0;
        volume      = 5'd0;
        sample_tick = 1'b0;
        frame_start = 1'b0;
        src_normal  = c_SRC_N;
        src_loud    = c_SRC_L;

        // ---------------- reset with random inputs ----------------
        for (int i = 0; i < 4; i++) begin
            enable      = 1'($urandom);
            volume      = 5'($urandom);
            sample_tick = 1'($urandom);
            frame_start = 1'($urandom);
            @(posedge basys_clock);
            #1;
            check_out("reset", 3'd0, 1'b0, 1'b0);
        end
        enable = 1'b1;
        volume = 5'd0;
        sample_tick = 1'b0;
        frame_start = 1'b0;
        rst_n = 1'b1;
        cyc(1'b0, 1'b0);
        check_out("post_reset", 3'd0, 1'b0, 1'b0);

        // ---------------- attack, then frame-aligned commit ----------------
        volume = 5'd12;
        for (int i = 1; i <= 4; i++) begin
            cyc(1'b1, 1'b0);
            cyc(1'b0, 1'b0);
            cyc(1'b0, 1'b0);
            check_out("attack_tick", (i < 4) ? 3'd1 : 3'd2, 1'b0, 1'b0);
        end
        repeat (50) cyc(1'b0, 1'b0);
        check_out("loud_pend_wait", 3'd2, 1'b0, 1'b0);
        cyc(1'b0, 1'b1);
        check_out("loud_commit", 3'd3, 1'b1, 1'b1);
        cyc(1'b0, 1'b0);
        check_out("loud_commit_next", 3'd3, 1'b1, 1'b0);

        // ---------------- hysteresis and hold ----------------
        volume = 5'd8;
        cyc(1'b1, 1'b0);
        check_out("hyst_band", 3'd3, 1'b1, 1'b0);
        volume = 5'd5;
        repeat (4) cyc(1'b1, 1'b0);
        check_out("hold_4", 3'd4, 1'b1, 1'b0);
        volume = 5'd7;
        cyc(1'b1, 1'b0);
        check_out("hold_abort", 3'd3, 1'b1, 1'b0);
        volume = 5'd5;
        repeat (4) cyc(1'b1, 1'b0);
        check_out("hold_again_4", 3'd4, 1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        check_out("normal_pend", 3'd5, 1'b1, 1'b0);
        cyc(1'b0, 1'b1);
        check_out("normal_commit", 3'd0, 1'b0, 1'b1);

        // ---------------- attack abort ----------------
        volume = 5'd12;
        repeat (3) cyc(1'b1, 1'b0);
        check_out("abort_pre", 3'd1, 1'b0, 1'b0);
        volume = 5'd9;
        cyc(1'b1, 1'b0);
        check_out("abort", 3'd0, 1'b0, 1'b0);
        volume = 5'd12;
        repeat (3) cyc(1'b1, 1'b0);
        check_out("abort_restart3", 3'd1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        check_out("abort_restart4", 3'd2, 1'b0, 1'b0);

        // tick and frame_start together in LOUD_PEND: the quiet tick is dropped
        volume = 5'd3;
        cyc(1'b1, 1'b1);
        check_out("pend_simul", 3'd3, 1'b1, 1'b1);
        // frame_start outside PEND states does nothing
        cyc(1'b0, 1'b1);
        check_out("loud_frame_ignored", 3'd3, 1'b1, 1'b0);

        // ---------------- NORMAL_PEND re-arm ----------------
        volume = 5'd5;
        repeat (5) cyc(1'b1, 1'b0);
        check_out("rearm_pend", 3'd5, 1'b1, 1'b0);
        volume = 5'd15;
        cyc(1'b1, 1'b0);
        check_out("rearm", 3'd3, 1'b1, 1'b0);

        // ---------------- enable drop ----------------
        enable = 1'b0;
        cyc(1'b0, 1'b0);
        check_out("enable_drop", 3'd0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        check_out("enable_drop_next", 3'd0, 1'b0, 1'b0);
        repeat (5) cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        check_out("disabled_ignore", 3'd0, 1'b0, 1'b0);
        enable = 1'b1;
        // in NORMAL the tick wins over a coincident frame_start
        cyc(1'b1, 1'b1);
        check_out("normal_simul", 3'd1, 1'b0, 1'b0);

        // ---------------- asynchronous reset mid-operation ----------------
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_reset", 3'd0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        check_out("async_reset_held", 3'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        cyc(1'b0, 1'b0);

        // four commits with a pulse: loud, normal, simultaneous loud, enable drop
        n_checks++;
        assert (n_pulses == 4) else begin
            n_err++;
            $error("FAIL pulse_count: observed %0d expected %0d", n_pulses, 4);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/visualiser_mode_ctrl.md
# visualiser_mode_ctrl

Frame-synchronous mode controller that decides when the OLED shows the high-volume image instead of the normal volume visualiser. It applies attack qualification, hysteresis and a hold timer to the 5-bit audio level so the display does not flicker near threshold. It commits source changes only at frame boundaries so a frame is never torn, and drives the final `oled_data` mux between the two pixel sources.

## Interface
Parameters:
- `HI_THRESH`, 10, volume at or above which a sample counts as loud.
- `LO_THRESH`, 7, volume below which a sample counts as quiet; must be < `HI_THRESH`.
- `ATTACK_SAMPLES`, 4, consecutive loud samples needed to request the loud image; ≥ 1.
- `HOLD_SAMPLES`, 2000, consecutive quiet samples needed to return to normal (100 ms at 20 kHz); 1..65535.

Ports:
- `basys_clock`  in  1  system clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  loud-mode enable (sw[6]); low forces normal display.
- `volume`  in  5  current audio level, unsigned.
- `sample_tick`  in  1  one-cycle pulse per 20 kHz sample, synchronous to `basys_clock`.
- `frame_start`  in  1  one-cycle pulse when `pixel_index` wraps to 0, synchronous to `basys_clock`.
- `src_normal`  in  16  normal visualiser pixel.
- `src_loud`  in  16  loud image pixel.
- `oled_data`  out  16  selected pixel.
- `loud_active`  out  1  registered select; 1 means the loud image is shown.
- `state_o`  out  3  FSM state encoding.
- `switch_pulse`  out  1  one-cycle pulse on the edge where `loud_active` changes.

## Operation
- `oled_data` = `loud_active` ? `src_loud` : `src_normal` (combinational mux, no extra latency).
- 16-bit counter `cnt`. Comparisons are unsigned on 5 bits.
- States (encoding): NORMAL=0, ATTACK=1, LOUD_PEND=2, LOUD=3, HOLD=4, NORMAL_PEND=5.
- NORMAL (sel=0): tick with volume ≥ HI → ATTACK, cnt=1. If `ATTACK_SAMPLES`=1, go directly to LOUD_PEND.
- ATTACK: tick with volume ≥ HI → cnt+1; when cnt+1 = `ATTACK_SAMPLES` → LOUD_PEND. Tick with volume < HI → NORMAL, cnt=0.
- LOUD_PEND: `frame_start` → LOUD, sel←1, pulse. Ticks are ignored.
- LOUD (sel=1): tick with volume < LO → HOLD, cnt=1. If `HOLD_SAMPLES`=1, go directly to NORMAL_PEND. Volume in [LO, HI) keeps LOUD.
- HOLD: tick with volume ≥ LO → LOUD, cnt=0. Tick with volume < LO → cnt+1; when cnt+1 = `HOLD_SAMPLES` → NORMAL_PEND.
- NORMAL_PEND: `frame_start` → NORMAL, sel←0, pulse. Tick with volume ≥ HI → LOUD, sel stays 1, no pulse.
- `enable` low, any state: next edge goes to NORMAL, cnt=0. If sel was 1, sel←0 immediately with pulse (user action overrides frame alignment).
- While `enable` is low, the FSM stays in NORMAL and ignores ticks.

## Timing
- Reset (async assert, sync release through the flops): state=NORMAL, cnt=0, `loud_active`=0, `switch_pulse`=0, `state_o`=0, `oled_data`=`src_normal`.
- Reset mid-operation returns to NORMAL within the assertion, with no pulse.
- State, sel and pulse update one edge after the qualifying tick/frame_start. `loud_active` is valid the cycle after the commit edge.
- `sample_tick` and `frame_start` in the same cycle:
  - PEND states: `frame_start` wins, the tick is dropped.
  - Other states: `frame_start` is ignored and the tick is processed.
- Cycles without `sample_tick` never change state except for the PEND/`frame_start` and `enable` rules.
- `switch_pulse` is never high for two consecutive cycles.
- Minimum loud-enter latency: `ATTACK_SAMPLES` ticks, plus the wait to the next `frame_start`, plus 1 cycle.

## Test plan
- Reset: hold `rst_n`=0 with random inputs → all outputs 0, `oled_data`=`src_normal`. Release → still NORMAL.
- Attack: volume=12 for 4 ticks, `frame_start` 50 cycles later → state 1→2 after tick 4. At the frame_start edge, `loud_active`=1, one `switch_pulse`, `oled_data`=`src_loud`.
- Attack abort: volume 12,12,12,9 → back to NORMAL, cnt=0, no pulse. The next 3 loud ticks alone do not reach LOUD_PEND.
- Hysteresis/hold (`HOLD_SAMPLES`=5): in LOUD, volume=8 → stays LOUD. Volume 5×4 then 7 → returns to LOUD. Volume 5×5 then `frame_start` → `loud_active`=0 with pulse.
- NORMAL_PEND re-arm plus simultaneity: in NORMAL_PEND, tick with volume=15 → LOUD, no pulse. In LOUD_PEND, tick and `frame_start` in the same cycle → LOUD committed.
- `enable` drop while LOUD → next edge NORMAL, `loud_active`=0, single pulse. Loud ticks are then ignored until `enable`=1.
